// File: rtl/bus_timer_pkg.sv
// Shared constants for the memory-mapped system timers: base addresses,
// register selects, CTRL bit positions, MODE encodings and FSM states.
package bus_timer_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CTRL_W = 4;

    // Timer instance base addresses and decoded span (three 32-bit words)
    localparam logic [31:0] T0_BASE = 32'h0000_7f00;
    localparam logic [31:0] T1_BASE = 32'h0000_7f10;
    localparam logic [31:0] SPAN    = 32'h0000_000b;

    // Register selects taken from addr[3:2]
    localparam logic [1:0] SEL_CTRL   = 2'd0;
    localparam logic [1:0] SEL_PRESET = 2'd1;
    localparam logic [1:0] SEL_COUNT  = 2'd2;

    // CTRL bit positions
    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_MODE_LO = 1;
    localparam int unsigned CTRL_MODE_HI = 2;
    localparam int unsigned CTRL_IM      = 3;

    // MODE encodings; 1x behaves as one-shot
    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    // Only the exact auto-reload encoding reloads; everything else is one-shot
    function automatic logic is_reload(input logic [1:0] mode);
        return (mode == MODE_RELOAD);
    endfunction

endpackage

// File: rtl/bus_timer.sv
// Memory-mapped down-counting timer with one-shot / auto-reload modes and a
// maskable level interrupt. Registers: CTRL, PRESET, COUNT (read-only).
module bus_timer
    import bus_timer_pkg::*;
#(
    parameter logic [31:0] BASE = T0_BASE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    state_t              r_state;
    logic [CTRL_W-1:0]   r_ctrl;
    logic [DATA_W-1:0]   r_preset;
    logic [DATA_W-1:0]   r_count;
    logic                r_irq_flag;

    logic                w_hit;
    logic [1:0]          w_sel;
    logic                w_wr;
    logic                w_wr_ctrl;
    logic                w_wr_preset;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   w_count_nxt;
    logic                w_flag_set;
    logic                w_flag_clr;
    logic                w_en_clr;
    logic                w_en;
    logic [1:0]          w_mode;

    // Address decode and write qualification (full-word writes only)
    assign w_hit       = (addr >= BASE) && (addr <= (BASE + SPAN));
    assign w_sel       = addr[3:2];
    assign w_wr        = w_hit && (byteen == 4'b1111);
    assign w_wr_ctrl   = w_wr && (w_sel == SEL_CTRL);
    assign w_wr_preset = w_wr && (w_sel == SEL_PRESET);
    assign w_en        = r_ctrl[CTRL_EN];
    assign w_mode      = r_ctrl[CTRL_MODE_HI:CTRL_MODE_LO];

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, next-count and flag/enable side effects
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_flag_set  = 1'b0;
        w_flag_clr  = 1'b0;
        w_en_clr    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_en) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_count_nxt = r_preset;
                w_state_nxt = ST_CNT;
            end
            ST_CNT: begin
                if (!w_en) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_count > 32'd1) begin
                    w_count_nxt = r_count - 32'd1;
                end else begin
                    w_count_nxt = '0;
                    w_flag_set  = 1'b1;
                    w_state_nxt = ST_INT;
                end
            end
            ST_INT: begin
                if (is_reload(w_mode)) begin
                    w_flag_clr  = 1'b1;
                    w_state_nxt = ST_LOAD;
                end else begin
                    w_en_clr    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // CTRL: CPU write wins over the one-shot EN clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ctrl <= '0;
        end else if (w_wr_ctrl) begin
            r_ctrl <= wdata[CTRL_W-1:0];
        end else if (w_en_clr) begin
            r_ctrl[CTRL_EN] <= 1'b0;
        end
    end

    // PRESET is only sampled by the FSM in LOAD
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_preset <= '0;
        end else if (w_wr_preset) begin
            r_preset <= wdata;
        end
    end

    // COUNT is owned by the FSM; CPU writes to it are dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_nxt;
        end
    end

    // Interrupt flag: expiry sets it; a CTRL write or an auto-reload clears it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq_flag <= 1'b0;
        end else if (w_flag_set) begin
            r_irq_flag <= 1'b1;
        end else if (w_wr_ctrl || w_flag_clr) begin
            r_irq_flag <= 1'b0;
        end
    end

    // Combinational read mux; zero outside the decoded window
    always_comb begin
        rdata = '0;
        if (w_hit) begin
            case (w_sel)
                SEL_CTRL:   rdata = {28'b0, r_ctrl};
                SEL_PRESET: rdata = r_preset;
                SEL_COUNT:  rdata = r_count;
                default:    rdata = '0;
            endcase
        end
    end

    assign irq = r_irq_flag & r_ctrl[CTRL_IM];

endmodule

// File: tb/tb_bus_timer.sv
// Bench for bus_timer: directed scenarios plus random bus traffic, all
// checked every cycle against a behavioural timer model.
module tb_bus_timer;

    localparam logic [31:0] B      = 32'h0000_7f00;
    localparam logic [31:0] A_CTRL = B;
    localparam logic [31:0] A_PRE  = B + 32'd4;
    localparam logic [31:0] A_CNT  = B + 32'd8;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int checks = 0;
    int errors = 0;

    // Behavioural model: phase 0 idle, 1 about to reload, 2 counting, 3 expired
    logic [3:0]  m_ctrl;
    logic [31:0] m_preset;
    logic [31:0] m_count;
    logic        m_flag;
    int          m_phase;

    bus_timer #(.BASE(B)) dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .byteen (byteen),
        .wdata  (wdata),
        .rdata  (rdata),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        logic [1:0] s;
        s = a[3:2];
        if (a < B || a > B + 32'hb) return 32'h0;
        case (s)
            2'd0:    return {28'b0, m_ctrl};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_ctrl = '0; m_preset = '0; m_count = '0; m_flag = 1'b0; m_phase = 0;
    endtask

    task automatic model_step(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        logic        acc;
        logic        wc;
        logic        wp;
        logic        en;
        logic        reload;
        logic        fired;
        logic [3:0]  nctrl;
        logic [31:0] ncnt;
        logic        nflag;
        int          nph;
        acc    = (a >= B) && (a <= B + 32'hb) && (be == 4'hf);
        wc     = acc && (a[3:2] == 2'd0);
        wp     = acc && (a[3:2] == 2'd1);
        en     = m_ctrl[0];
        reload = (m_ctrl[2:1] == 2'b01);
        nctrl  = m_ctrl; ncnt = m_count; nflag = m_flag; nph = m_phase;
        fired  = 1'b0;
        if (m_phase == 0) begin
            if (en) nph = 1;
        end else if (m_phase == 1) begin
            ncnt = m_preset; nph = 2;
        end else if (m_phase == 2) begin
            if (!en) nph = 0;
            else if (m_count > 32'd1) ncnt = m_count - 32'd1;
            else begin ncnt = 32'd0; nflag = 1'b1; fired = 1'b1; nph = 3; end
        end else begin
            if (reload) begin nflag = 1'b0; nph = 1; end
            else begin nctrl[0] = 1'b0; nph = 0; end
        end
        if (wc) begin
            nctrl = d[3:0];
            if (!fired) nflag = 1'b0;
        end
        if (wp) m_preset = d;
        m_ctrl = nctrl; m_count = ncnt; m_flag = nflag; m_phase = nph;
    endtask

    // One bus cycle, entered and left at the falling edge
    task automatic bus_cycle(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        addr = a; byteen = be; wdata = d;
        #1;
        chk("rdata", rdata, model_rd(a));
        chk("irq", 32'(irq), 32'(m_flag & m_ctrl[3]));
        @(posedge clk);
        model_step(a, be, d);
        @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus_cycle(a, 4'hf, d);
    endtask

    task automatic rd(input logic [31:0] a);
        bus_cycle(a, 4'h0, 32'h0);
    endtask

    task automatic idle();
        bus_cycle(A_CNT, 4'h0, 32'h0);
    endtask

    // Asynchronous reset pulse placed between clock edges
    task automatic pulse_reset();
        #2;
        reset = 1'b1;
        model_reset();
        addr = A_CNT; byteen = 4'h0; #1;
        chk("rst_count", rdata, 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        addr = A_CTRL; #1;
        chk("rst_ctrl", rdata, 32'h0);
        addr = A_PRE; #1;
        chk("rst_preset", rdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int n;
        int q[$];
        int k;
        logic [31:0] a;
        logic [3:0]  be;
        logic [31:0] d;

        reset = 1'b1; addr = A_CTRL; byteen = 4'h0; wdata = 32'h0;
        model_reset();
        #12;
        chk("reset_ctrl", rdata, 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // One-shot with interrupt enabled
        wr(A_PRE, 32'd5);
        wr(A_CTRL, 32'h9);
        n = 0;
        while (!irq && n < 50) begin idle(); n++; end
        chk("oneshot_latency", 32'(n), 32'd7);
        chk("oneshot_count", rdata, 32'd0);
        repeat (3) idle();
        chk("oneshot_irq_held", 32'(irq), 32'd1);
        rd(A_CTRL);
        chk("oneshot_en_cleared", rdata, 32'h8);
        wr(A_CTRL, 32'h0);
        chk("oneshot_irq_dropped", 32'(irq), 32'd0);

        // Auto-reload pulses
        wr(A_PRE, 32'd3);
        wr(A_CTRL, 32'hb);
        q.delete();
        for (int i = 0; i < 30; i++) begin
            idle();
            if (irq) q.push_back(i);
        end
        chk("reload_pulses", 32'(q.size() >= 5), 32'd1);
        for (int i = 1; i < q.size(); i++) chk("reload_period", 32'(q[i] - q[i-1]), 32'd5);

        // Partial writes, read-only COUNT, masked interrupt
        wr(A_CTRL, 32'h0);
        repeat (3) idle();
        wr(A_PRE, 32'd4);
        wr(A_CTRL, 32'h1);
        bus_cycle(A_PRE, 4'b0011, 32'd9);
        rd(A_PRE);
        chk("partial_write_ignored", rdata, 32'd4);
        wr(A_CNT, 32'd7);
        repeat (8) idle();
        chk("masked_irq", 32'(irq), 32'd0);
        chk("masked_flag", 32'(dut.r_irq_flag), 32'd1);

        // Disable mid-count, then re-enable
        wr(A_CTRL, 32'h0);
        wr(A_PRE, 32'd20);
        wr(A_CTRL, 32'h1);
        n = 0;
        while (rdata != 32'd10 && n < 100) begin idle(); n++; end
        chk("reach_ten", 32'(n < 100), 32'd1);
        wr(A_CTRL, 32'h0);
        repeat (3) idle();
        chk("frozen_count", rdata, 32'd9);
        repeat (5) idle();
        chk("still_frozen", rdata, 32'd9);
        wr(A_CTRL, 32'h1);
        idle(); idle();
        chk("reload_on_reenable", rdata, 32'd20);

        // Reset mid-count
        wr(A_PRE, 32'd50);
        wr(A_CTRL, 32'h9);
        repeat (10) idle();
        pulse_reset();
        repeat (60) idle();
        chk("no_irq_after_reset", 32'(irq), 32'd0);

        // Misses do not alias or change state
        wr(A_PRE, 32'd6);
        wr(B + 32'hc, 32'hffff_ffff);
        wr(B + 32'h20, 32'hffff_ffff);
        wr(B + 32'h10, 32'hffff_ffff);
        wr(B - 32'd4, 32'hffff_ffff);
        rd(B + 32'hc);
        chk("miss_0c", rdata, 32'h0);
        rd(B + 32'h20);
        chk("miss_20", rdata, 32'h0);
        rd(A_PRE + 32'd3);
        chk("preset_kept", rdata, 32'd6);
        rd(A_CTRL);
        chk("ctrl_kept", rdata, 32'h0);

        // Random traffic against the model
        for (int i = 0; i < 800; i++) begin
            k = $urandom_range(0, 9);
            if (k < 7)       a = B + 32'(4 * $urandom_range(0, 2)) + 32'($urandom_range(0, 3));
            else if (k == 7) a = B + 32'hc + 32'($urandom_range(0, 3));
            else if (k == 8) a = B - 32'd4;
            else             a = $urandom;
            k = $urandom_range(0, 7);
            if (k == 0)      be = 4'($urandom);
            else if (k <= 2) be = 4'hf;
            else             be = 4'h0;
            d = (a[3:2] == 2'd1) ? 32'($urandom_range(0, 6)) : $urandom;
            bus_cycle(a, be, d);
            if ($urandom_range(0, 199) == 0) pulse_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_timer.md
BUS_TIMER -- requirements
Module: bus_timer

Interface
REQ-001 SHALL have parameter BASE, default 32'h0000_7f00, meaning byte address of the first register.
REQ-002 SHALL have port clk, input, 1, system clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port addr, input, 32, byte address issued by the CPU data port.
REQ-005 SHALL have port byteen, input, 4, write byte enables; nonzero means a write request.
REQ-006 SHALL have port wdata, input, 32, write data.
REQ-007 SHALL have port rdata, output, 32, combinational read data.
REQ-008 SHALL have port irq, output, 1, interrupt request, level.

Function
REQ-009 SHALL decode a hit when BASE <= addr <= BASE+32'hb; register select is addr[3:2]: 0 CTRL, 1 PRESET, 2 COUNT.
REQ-010 SHALL accept a write only on a hit with byteen == 4'b1111; partial byteen and misses are ignored with no state change.
REQ-011 SHALL ignore writes to COUNT, because COUNT is read-only.
REQ-012 SHALL store only CTRL[3:0]: [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as 00), [3] IM; CTRL[31:4] reads 0.
REQ-013 SHALL drive rdata as {28'b0,CTRL} at select 0, PRESET at 1, COUNT at 2; rdata is 0 on a miss, and addr[1:0] is ignored.
REQ-014 SHALL implement FSM states IDLE, LOAD, CNT, INT, with reset state IDLE.
REQ-015 SHALL leave IDLE only when EN=1, going to LOAD.
REQ-016 SHALL, in LOAD, set COUNT <= PRESET and go to CNT.
REQ-017 SHALL, in CNT with EN=0, go to IDLE with COUNT held.
REQ-018 SHALL, in CNT with EN=1 and COUNT>1, decrement COUNT.
REQ-019 SHALL, in CNT with EN=1 and COUNT<=1, set COUNT <= 0, set irq_flag <= 1, and go to INT.
REQ-020 SHALL, in INT with MODE one-shot, clear EN and go to IDLE; irq_flag holds until the next accepted CTRL write clears it.
REQ-021 SHALL, in INT with MODE auto-reload, clear irq_flag and go to LOAD, so irq_flag is high for exactly one cycle.
REQ-022 SHALL drive irq = irq_flag & IM, combinationally.
REQ-023 SHALL give timing for PRESET=N>=1 with EN written at edge E0: LOAD after E1, COUNT=N after E2, irq_flag=1 after E(N+2).
REQ-024 SHALL treat PRESET=0 like PRESET=1, with irq_flag=1 after E3.
REQ-025 SHALL let a PRESET write during CNT take effect only at the next LOAD.
REQ-026 SHALL give a CPU CTRL write priority over an FSM EN clear in the same cycle (INT, one-shot).
REQ-027 SHALL make the FSM observe the new EN on the cycle after a CTRL write.
REQ-028 SHALL wrap no arithmetic: COUNT never decrements below 0, and COUNT is 32 bits unsigned.

Reset
REQ-029 SHALL, on reset, set CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state=IDLE, and therefore irq=0, regardless of clk.
REQ-030 SHALL, on reset mid-count, abort immediately with no interrupt afterwards until re-enabled.

Structure
REQ-031 SHALL take the timer base addresses (T0 32'h7f00, T1 32'h7f10), register offsets, CTRL bit positions, MODE encodings and FSM state encodings from the shared constants include.
REQ-032 SHALL be a single module with no sub-module; two instances with BASE=T0 and T1 form the system timers.

Verification
REQ-033 SHALL verify: write PRESET=5, then CTRL=4'b1001 -> irq rises 7 edges after the CTRL write edge, COUNT=0, EN reads 0, and irq stays high until a CTRL write of 0 drops it next cycle.
REQ-034 SHALL verify: PRESET=3, CTRL=4'b1011 -> irq one-cycle pulses with period 5 cycles, and COUNT sequence 3,2,1,0,(reload)3.
REQ-035 SHALL verify: CTRL=4'b0001, PRESET=4, byteen=4'b0011 write of PRESET=9 -> PRESET stays 4; write of COUNT=7 -> COUNT unchanged; irq stays 0 with IM=0 while the internal flag sets.
REQ-036 SHALL verify: during CNT at COUNT=10, write CTRL EN=0 -> COUNT frozen at its next value and FSM IDLE; re-enable -> LOAD reloads PRESET.
REQ-037 SHALL verify: assert reset mid-count asynchronously between edges -> all registers 0 and irq 0 immediately.
REQ-038 SHALL verify: read addr 32'h7f0c and 32'h7f20 on a BASE=32'h7f00 instance -> rdata 0 and no state change on write.
